disp_scan_ctrl: RTL

Four-digit seven-segment scan controller that time-multiplexes a 16-bit hex value onto one shared segment bus. It sits directly upstream of the 2-to-4 digit-select decoder: `sel` drives the decoder's `x` input and `sel_en` drives its `en` input. `hex_out` and `dp_out` feed the hex-to-segment encoder. Each slot has an optional blanking interval to suppress ghosting. Inputs are snapshotted once per frame so the display never tears.

---
 rtl/disp_scan_ctrl.sv | 128 ++++++++++++
 1 files changed

// File: rtl/disp_scan_ctrl.sv
// Four-digit seven-segment scan controller: time-multiplexes a frame-snapshotted
// 16-bit hex value onto a shared segment bus with an optional per-slot blanking gap.
module disp_scan_ctrl #(
    parameter int DIV   = 50000,
    parameter int DEAD  = 500,
    parameter int CNT_W = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        run,
    input  logic [15:0] hex_in,
    input  logic [3:0]  dp_in,
    input  logic [3:0]  blank_in,
    output logic [1:0]  sel,
    output logic        sel_en,
    output logic [3:0]  hex_out,
    output logic        dp_out,
    output logic        frame_tick
);

    typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] DEAD_LAST  = CNT_W'((DEAD > 0) ? DEAD - 1 : 0);
    localparam state_t           SLOT_START = (DEAD == 0) ? SHOW : BLANK;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       sel_q, sel_d;
    logic [15:0]      hex_s_q, hex_s_d;
    logic [3:0]       dp_s_q, dp_s_d;
    logic [3:0]       blank_s_q, blank_s_d;
    logic             sel_en_q, sel_en_d;
    logic [3:0]       hex_out_q, hex_out_d;
    logic             dp_out_q, dp_out_d;
    logic             tick_q, tick_d;
    logic             load;
    logic [1:0]       nib_idx;

    function automatic logic [3:0] nibble(input logic [15:0] v, input logic [1:0] i);
        case (i)
            2'd0:    return v[3:0];
            2'd1:    return v[7:4];
            2'd2:    return v[11:8];
            default: return v[15:12];
        endcase
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        load    = 1'b0;
        tick_d  = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                sel_d = 2'd0;
                if (run) begin
                    load    = 1'b1;
                    state_d = SLOT_START;
                end
            end
            default: begin
                if (!run) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    sel_d   = 2'd0;
                end else if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    sel_d   = sel_q + 2'd1;
                    state_d = SLOT_START;
                    if (sel_q == 2'd3) begin
                        load   = 1'b1;
                        tick_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (DEAD > 0 && state_q == BLANK && cnt_q == DEAD_LAST)
                        state_d = SHOW;
                end
            end
        endcase

        hex_s_d   = load ? hex_in   : hex_s_q;
        dp_s_d    = load ? dp_in    : dp_s_q;
        blank_s_d = load ? blank_in : blank_s_q;

        // sel=k shows nibble 3-k, i.e. the bitwise inverse of the 2-bit index.
        nib_idx   = ~sel_d;
        hex_out_d = (state_d == IDLE) ? 4'h0 : nibble(hex_s_d, nib_idx);
        dp_out_d  = (state_d != IDLE) && dp_s_d[nib_idx];
        sel_en_d  = (state_d == SHOW) && !blank_s_d[nib_idx];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            sel_q     <= 2'd0;
            hex_s_q   <= '0;
            dp_s_q    <= '0;
            blank_s_q <= '0;
            sel_en_q  <= 1'b0;
            hex_out_q <= '0;
            dp_out_q  <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sel_q     <= sel_d;
            hex_s_q   <= hex_s_d;
            dp_s_q    <= dp_s_d;
            blank_s_q <= blank_s_d;
            sel_en_q  <= sel_en_d;
            hex_out_q <= hex_out_d;
            dp_out_q  <= dp_out_d;
            tick_q    <= tick_d;
        end
    end

    assign sel        = sel_q;
    assign sel_en     = sel_en_q;
    assign hex_out    = hex_out_q;
    assign dp_out     = dp_out_q;
    assign frame_tick = tick_q;

endmodule
